// File: rtl/debug_view_pkg.sv
// Shared types and index helpers for the board debug display.
// Views are CH*4 probe bytes followed by a single flags view.
package debug_view_pkg;

    localparam int LED_W = 8;

    typedef enum logic {
        LIVE   = 1'b0,
        FROZEN = 1'b1
    } frz_state_e;

    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

    function automatic int view_count(input int ch);
        return ch * 4 + 1;
    endfunction

    function automatic int flags_idx(input int ch);
        return ch * 4;
    endfunction

endpackage

// File: rtl/led_debug_viewer_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, counting debouncer
// and a single-cycle pulse on an accepted press.
module btn_debounce
    import debug_view_pkg::*;
#(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          lvl_q;
    logic          lvl_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // A matching sample (bounce back) restarts qualification.
    always_comb begin
        cnt_d = '0;
        lvl_d = lvl_q;
        if (sync2_q != lvl_q) begin
            if (cnt_q == CNT_MAX) begin
                lvl_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
        end
    end

    assign press_o = lvl_d & ~lvl_q;

endmodule

// File: rtl/led_debug_viewer.sv
// LED debug display: byte/flags view mux with auto-scan and a
// button-driven freeze that snapshots every probe channel.
module led_debug_viewer
    import debug_view_pkg::*;
#(
    parameter int CH         = 2,
    parameter int FLAG_W     = 2,
    parameter int SCAN_DIV   = 50000000,
    parameter int DEB_CYCLES = 1000000,
    parameter int SEL_W      = 5
) (
    input  logic                 clk_100MHz,
    input  logic                 rst,
    input  logic [CH*32-1:0]     probe_bus,
    input  logic [FLAG_W-1:0]    flags,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 auto_mode,
    input  logic                 btn_freeze,
    output logic [LED_W-1:0]     LED,
    output logic [SEL_W-1:0]     scan_idx,
    output logic                 frozen
);

    localparam int NV = view_count(CH);
    localparam int TW = clog2(SCAN_DIV);
    localparam logic [SEL_W-1:0] IDX_LAST  = SEL_W'(NV - 1);
    localparam logic [SEL_W-1:0] IDX_FLAGS = SEL_W'(flags_idx(CH));
    localparam logic [TW-1:0]    TMAX      = TW'(SCAN_DIV - 1);

    logic               press;
    frz_state_e         state_q;
    frz_state_e         state_d;
    logic [CH*32-1:0]   snap_bus_q;
    logic [CH*32-1:0]   snap_bus_d;
    logic [FLAG_W-1:0]  snap_flags_q;
    logic [FLAG_W-1:0]  snap_flags_d;
    logic [TW-1:0]      timer_q;
    logic [TW-1:0]      timer_d;
    logic [SEL_W-1:0]   idx_q;
    logic [SEL_W-1:0]   idx_d;
    logic               auto_q;
    logic [LED_W-1:0]   led_q;
    logic [LED_W-1:0]   led_d;
    logic [CH*32-1:0]   src_bus;
    logic [FLAG_W-1:0]  src_flags;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_btn (
        .clk_i  (clk_100MHz),
        .rst_i  (rst),
        .btn_i  (btn_freeze),
        .press_o(press)
    );

    always_comb begin
        timer_d = '0;
        idx_d   = sel;
        if (auto_mode) begin
            if (!auto_q) begin
                idx_d = '0;
            end else if (timer_q == TMAX) begin
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
                idx_d   = idx_q;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        snap_bus_d   = snap_bus_q;
        snap_flags_d = snap_flags_q;
        if (press) begin
            unique case (state_q)
                LIVE: begin
                    state_d      = FROZEN;
                    snap_bus_d   = probe_bus;
                    snap_flags_d = flags;
                end
                FROZEN: begin
                    state_d = LIVE;
                end
                default: state_d = LIVE;
            endcase
        end
    end

    assign src_bus   = (state_q == FROZEN) ? snap_bus_q : probe_bus;
    assign src_flags = (state_q == FROZEN) ? snap_flags_q : flags;

    // Probe byte i sits at bits [8i+7:8i]; indices past the flags view read 0.
    always_comb begin
        led_d = '0;
        for (int i = 0; i < CH * 4; i++) begin
            if (idx_d == SEL_W'(i)) begin
                led_d = src_bus[i*8 +: 8];
            end
        end
        if (idx_d == IDX_FLAGS) begin
            led_d = LED_W'(src_flags);
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            state_q      <= LIVE;
            snap_bus_q   <= '0;
            snap_flags_q <= '0;
            timer_q      <= '0;
            idx_q        <= '0;
            auto_q       <= 1'b0;
            led_q        <= '0;
        end else begin
            state_q      <= state_d;
            snap_bus_q   <= snap_bus_d;
            snap_flags_q <= snap_flags_d;
            timer_q      <= timer_d;
            idx_q        <= idx_d;
            auto_q       <= auto_mode;
            led_q        <= led_d;
        end
    end

    assign LED      = led_q;
    assign scan_idx = idx_q;
    assign frozen   = (state_q == FROZEN);

endmodule

// File: tb/tb_led_debug_viewer.sv
// Bench for led_debug_viewer: vector table, directed corner sequences
// and a randomized run against a behavioural reference model.
module tb_led_debug_viewer;

    localparam int CH  = 2;
    localparam int FW  = 2;
    localparam int SD  = 4;
    localparam int DEB = 8;
    localparam int SW  = 5;
    localparam int NV  = CH * 4 + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   probe;
    logic [1:0]    flags;
    logic [4:0]    sel;
    logic          auto_mode;
    logic          btn;
    logic [7:0]    led;
    logic [4:0]    scan_idx;
    logic          frozen;

    always #5 clk = ~clk;

    led_debug_viewer #(
        .CH(CH), .FLAG_W(FW), .SCAN_DIV(SD), .DEB_CYCLES(DEB), .SEL_W(SW)
    ) dut (
        .clk_100MHz(clk),
        .rst       (rst),
        .probe_bus (probe),
        .flags     (flags),
        .sel       (sel),
        .auto_mode (auto_mode),
        .btn_freeze(btn),
        .LED       (led),
        .scan_idx  (scan_idx),
        .frozen    (frozen)
    );

    int nvec = 0;
    int nerr = 0;

    // reference model state
    logic [7:0]  m_led;
    int          m_idx;
    int          m_timer;
    bit          m_frz;
    bit          m_autop;
    bit          m_deb;
    logic [63:0] m_snap;
    logic [1:0]  m_snapf;
    bit          bq[$];
    bit          sq[$];

    function automatic logic [7:0] ref_view(logic [63:0] bus, logic [1:0] fl, int i);
        if (i < CH * 4) return bus[i*8 +: 8];
        if (i == CH * 4) return {6'b0, fl};
        return 8'h00;
    endfunction

    task automatic model_step();
        bit sync, press, all_diff;
        if (rst) begin
            m_led = 0; m_idx = 0; m_timer = 0; m_frz = 0; m_autop = 0;
            m_deb = 0; m_snap = 0; m_snapf = 0;
            bq.delete(); sq.delete();
            return;
        end
        // synchronized value seen now is the button from two edges ago
        sync = (bq.size() == 2) ? bq[0] : 1'b0;
        bq.push_back(btn);
        if (bq.size() > 2) void'(bq.pop_front());
        sq.push_back(sync);
        if (sq.size() > DEB) void'(sq.pop_front());
        press = 0;
        if (sq.size() == DEB) begin
            all_diff = 1;
            foreach (sq[j]) if (sq[j] == m_deb) all_diff = 0;
            if (all_diff) begin
                m_deb = !m_deb;
                press = m_deb;
                sq.delete();
            end
        end
        if (!auto_mode) begin
            m_timer = 0; m_idx = sel;
        end else if (!m_autop) begin
            m_timer = 0; m_idx = 0;
        end else if (m_timer == SD - 1) begin
            m_timer = 0; m_idx = (m_idx + 1) % NV;
        end else begin
            m_timer++;
        end
        m_autop = auto_mode;
        m_led = m_frz ? ref_view(m_snap, m_snapf, m_idx) : ref_view(probe, flags, m_idx);
        if (press) begin
            if (!m_frz) begin
                m_snap = probe; m_snapf = flags; m_frz = 1;
            end else begin
                m_frz = 0;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("model_led", led, m_led);
        chk("model_scan_idx", scan_idx, m_idx);
        chk("model_frozen", frozen, m_frz);
    endtask

    typedef struct {
        logic [4:0] sel;
        logic [1:0] fl;
        logic [7:0] led;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int waited;
        int prev;
        int hold;
        tbl[0]  = '{5'd0,  2'b10, 8'h78};
        tbl[1]  = '{5'd3,  2'b10, 8'h12};
        tbl[2]  = '{5'd5,  2'b10, 8'hBA};
        tbl[3]  = '{5'd7,  2'b10, 8'hCA};
        tbl[4]  = '{5'd1,  2'b10, 8'h56};
        tbl[5]  = '{5'd4,  2'b10, 8'hBE};
        tbl[6]  = '{5'd6,  2'b10, 8'hFE};
        tbl[7]  = '{5'd8,  2'b10, 8'h02};
        tbl[8]  = '{5'd9,  2'b10, 8'h00};
        tbl[9]  = '{5'd15, 2'b10, 8'h00};
        tbl[10] = '{5'd31, 2'b10, 8'h00};
        tbl[11] = '{5'd8,  2'b01, 8'h01};

        rst = 1; probe = {32'hCAFEBABE, 32'h12345678}; flags = 2'b10;
        sel = 0; auto_mode = 0; btn = 0;
        tick(); tick();
        chk("reset_led", led, 8'h00);
        chk("reset_idx", scan_idx, 0);
        chk("reset_frozen", frozen, 0);
        rst = 0;

        for (int i = 0; i < 12; i++) begin
            sel = tbl[i].sel; flags = tbl[i].fl;
            tick();
            chk("tbl_led", led, tbl[i].led);
            chk("tbl_idx", scan_idx, tbl[i].sel);
        end

        flags = 2'b10; sel = 5'd3;
        auto_mode = 1;
        tick();
        chk("auto_entry", scan_idx, 0);
        for (int c = 1; c <= 36; c++) begin
            tick();
            chk("auto_seq", scan_idx, (c / 4) % NV);
        end
        repeat (6) tick();
        auto_mode = 0; tick();
        auto_mode = 1; tick();
        chk("auto_restart", scan_idx, 0);
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk("auto_restart_seq", scan_idx, (c / 4) % NV);
        end

        auto_mode = 0; sel = 0;
        btn = 1; repeat (3) tick();
        btn = 0; repeat (2) tick();
        btn = 1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            chk("freeze_timing", frozen, t >= 10);
        end
        probe[31:0] = 32'h0;
        tick();
        chk("frozen_hold", led, 8'h78);
        btn = 0; repeat (12) tick();
        chk("frozen_after_release", frozen, 1);
        btn = 1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            chk("unfreeze_timing", frozen, t < 10);
            if (t == 11) chk("unfreeze_led", led, 8'h00);
        end
        btn = 0; repeat (12) tick();

        probe = {32'hCAFEBABE, 32'h12345678};
        auto_mode = 1; tick();
        waited = 0;
        while (m_timer != 2 && waited < 20) begin tick(); waited++; end
        chk("align_in_time", waited < 20, 1);
        btn = 1;
        repeat (9) tick();
        probe[63:32] = 32'hDEADBEEF;
        prev = m_idx;
        tick();
        chk("coinc_frozen", frozen, 1);
        chk("coinc_idx", scan_idx, (prev + 1) % NV);
        probe[63:32] = 32'h0;
        waited = 0;
        while (m_idx != 5 && waited < 40) begin tick(); waited++; end
        chk("snap_view_in_time", waited < 40, 1);
        chk("snap_ch1_byte1", led, 8'hBE);

        rst = 1; tick(); rst = 0;
        chk("midrst_led", led, 8'h00);
        chk("midrst_idx", scan_idx, 0);
        chk("midrst_frozen", frozen, 0);
        for (int t = 1; t <= 10; t++) begin
            tick();
            chk("requal_timing", frozen, t >= 10);
        end
        btn = 0; repeat (12) tick();

        hold = 0;
        for (int n = 0; n < 3000; n++) begin
            probe = {$urandom, $urandom};
            flags = 2'($urandom_range(0, 3));
            sel = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 149) == 0) auto_mode = !auto_mode;
            if (hold == 0) begin
                btn = !btn;
                hold = $urandom_range(1, 20);
            end else begin
                hold--;
            end
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
